// File: rtl/rht_pkg.sv
// Rename history table shared definitions.
// Holds the default configuration, the id/entry types used by the rename and
// commit stages, and the wrap-around adder used for all pointer arithmetic.
package rht_pkg;

  localparam int unsigned RHT_DEPTH_DFLT    = 128;
  localparam int unsigned L_ADDR_WIDTH_DFLT = 5;
  localparam int unsigned P_ADDR_WIDTH_DFLT = 8;
  localparam int unsigned INSTR_COUNT_DFLT  = 2;
  localparam int unsigned RD_PORTS_DFLT     = 2;

  localparam int unsigned RHT_TICKET = $clog2(RHT_DEPTH_DFLT);

  typedef logic [RHT_TICKET-1:0] rht_id_t;

  typedef struct packed {
    logic [L_ADDR_WIDTH_DFLT-1:0] ldst;
    logic [P_ADDR_WIDTH_DFLT-1:0] pdst;
  } rht_entry_t;

  // Modular add for pointers in [0, depth); depth need not be a power of two.
  // Both operands must already be below depth.
  function automatic int unsigned rht_wrap_add(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned depth);
    int unsigned s;
    s = a + b;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/rht_compact_alloc.sv
// Compacting id allocator for the rename history table.
// Valid push slots take consecutive ids starting at the tail in slot order;
// an invalid slot shows the id the next valid slot would get.
// Ports:
//   push_valid_i  per-slot push request (gaps allowed)
//   tail_i        current tail pointer
//   id_o          per-slot allocated id, INSTR_COUNT x log2(RHT_DEPTH)
//   n_push_o      number of valid slots
module rht_compact_alloc
  import rht_pkg::*;
#(
  parameter int unsigned RHT_DEPTH   = RHT_DEPTH_DFLT,
  parameter int unsigned INSTR_COUNT = INSTR_COUNT_DFLT,
  localparam int unsigned TW = $clog2(RHT_DEPTH),
  localparam int unsigned NW = $clog2(INSTR_COUNT + 1)
) (
  input  logic [INSTR_COUNT-1:0]    push_valid_i,
  input  logic [TW-1:0]             tail_i,
  output logic [INSTR_COUNT*TW-1:0] id_o,
  output logic [NW-1:0]             n_push_o
);

  always_comb begin
    int unsigned seen;
    seen = 0;
    id_o = '0;
    for (int unsigned k = 0; k < INSTR_COUNT; k++) begin
      id_o[k*TW +: TW] = TW'(rht_wrap_add(32'(tail_i), seen, RHT_DEPTH));
      seen += 32'(push_valid_i[k]);
    end
    n_push_o = NW'(seen);
  end

endmodule

// File: rtl/rht_queue.sv
// Rename history table queue.
// Circular buffer of {Ldst,Pdst} records: rename pushes at the tail (masked,
// compacted, multi-slot), commit pops at the head releasing Pdst, recovery
// restores the tail and walks entries through tagged read ports.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   push_valid/push_data_Ldst/Pdst   per-slot push request and payload
//   push_ready                       at least INSTR_COUNT free entries
//   id_out                           id allocated to each push slot
//   pop_count                        entries to retire from head
//   pop_Pdst/pop_valid               head entries' Pdst, retired-slot flags
//   set_ptr/new_pointer              redirect: restore tail
//   rd_id/rd_Ldst/rd_Pdst/rd_hit     read ports, hit when id is occupied
//   count/empty/full                 occupancy
module rht_queue
  import rht_pkg::*;
#(
  parameter int unsigned RHT_DEPTH    = RHT_DEPTH_DFLT,
  parameter int unsigned L_ADDR_WIDTH = L_ADDR_WIDTH_DFLT,
  parameter int unsigned P_ADDR_WIDTH = P_ADDR_WIDTH_DFLT,
  parameter int unsigned INSTR_COUNT  = INSTR_COUNT_DFLT,
  parameter int unsigned RD_PORTS     = RD_PORTS_DFLT,
  localparam int unsigned TW  = $clog2(RHT_DEPTH),
  localparam int unsigned CW  = $clog2(RHT_DEPTH + 1),
  localparam int unsigned PCW = $clog2(INSTR_COUNT + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INSTR_COUNT-1:0]            push_valid,
  input  logic [INSTR_COUNT*L_ADDR_WIDTH-1:0] push_data_Ldst,
  input  logic [INSTR_COUNT*P_ADDR_WIDTH-1:0] push_data_Pdst,
  output logic                              push_ready,
  output logic [INSTR_COUNT*TW-1:0]         id_out,
  input  logic [PCW-1:0]                    pop_count,
  output logic [INSTR_COUNT*P_ADDR_WIDTH-1:0] pop_Pdst,
  output logic [INSTR_COUNT-1:0]            pop_valid,
  input  logic                              set_ptr,
  input  logic [TW-1:0]                     new_pointer,
  input  logic [RD_PORTS*TW-1:0]            rd_id,
  output logic [RD_PORTS*L_ADDR_WIDTH-1:0]  rd_Ldst,
  output logic [RD_PORTS*P_ADDR_WIDTH-1:0]  rd_Pdst,
  output logic [RD_PORTS-1:0]               rd_hit,
  output logic [CW-1:0]                     count,
  output logic                              empty,
  output logic                              full
);

  typedef struct packed {
    logic [L_ADDR_WIDTH-1:0] ldst;
    logic [P_ADDR_WIDTH-1:0] pdst;
  } entry_t;

  entry_t              mem_q [RHT_DEPTH];
  logic [TW-1:0]       head_q, head_d;
  logic [TW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [INSTR_COUNT*TW-1:0] alloc_id;
  logic [PCW-1:0]      n_push;
  logic [PCW-1:0]      eff_pop;
  logic                push_fire;

  rht_compact_alloc #(
    .RHT_DEPTH  (RHT_DEPTH),
    .INSTR_COUNT(INSTR_COUNT)
  ) u_alloc (
    .push_valid_i(push_valid),
    .tail_i      (tail_q),
    .id_o        (alloc_id),
    .n_push_o    (n_push)
  );

  assign id_out     = alloc_id;
  assign push_ready = (32'(count_q) + INSTR_COUNT) <= RHT_DEPTH;
  // A redirect in the same cycle discards the push entirely.
  assign push_fire  = push_ready & (|push_valid) & ~set_ptr;
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (32'(count_q) == RHT_DEPTH);

  // Commit side: clamp the pop to the occupancy, expose head entries.
  always_comb begin
    eff_pop   = (32'(pop_count) < 32'(count_q)) ? pop_count : PCW'(count_q);
    pop_Pdst  = '0;
    pop_valid = '0;
    for (int unsigned k = 0; k < INSTR_COUNT; k++) begin
      pop_Pdst[k*P_ADDR_WIDTH +: P_ADDR_WIDTH] =
        mem_q[TW'(rht_wrap_add(32'(head_q), k, RHT_DEPTH))].pdst;
      pop_valid[k] = (k < 32'(eff_pop));
    end
  end

  // Pointer and occupancy update. Push, pop and flush terms are independent
  // so one combined expression covers every mix of them.
  always_comb begin
    int unsigned flushed;
    flushed = 0;
    if (set_ptr) begin
      flushed = (tail_q >= new_pointer) ? 32'(tail_q) - 32'(new_pointer)
                                        : 32'(tail_q) + RHT_DEPTH - 32'(new_pointer);
    end
    head_d = TW'(rht_wrap_add(32'(head_q), 32'(eff_pop), RHT_DEPTH));
    tail_d = tail_q;
    if (set_ptr) begin
      tail_d = new_pointer;
    end else if (push_fire) begin
      tail_d = TW'(rht_wrap_add(32'(tail_q), 32'(n_push), RHT_DEPTH));
    end
    count_d = CW'(32'(count_q) + (push_fire ? 32'(n_push) : 32'd0)
                  - 32'(eff_pop) - flushed);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; only slots marked valid are written.
  always_ff @(posedge clk) begin
    if (push_fire && !rst) begin
      for (int unsigned k = 0; k < INSTR_COUNT; k++) begin
        if (push_valid[k]) begin
          mem_q[alloc_id[k*TW +: TW]] <= '{
            ldst: push_data_Ldst[k*L_ADDR_WIDTH +: L_ADDR_WIDTH],
            pdst: push_data_Pdst[k*P_ADDR_WIDTH +: P_ADDR_WIDTH]
          };
        end
      end
    end
  end

  // Read ports. Ids past the last entry (non power-of-two depth) never hit.
  always_comb begin
    logic [TW-1:0] rid;
    int unsigned   off;
    entry_t        e;
    rd_Ldst = '0;
    rd_Pdst = '0;
    rd_hit  = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      rid = rd_id[p*TW +: TW];
      off = (rid >= head_q) ? 32'(rid) - 32'(head_q)
                            : 32'(rid) + RHT_DEPTH - 32'(head_q);
      e   = (32'(rid) < RHT_DEPTH) ? mem_q[rid] : '0;
      rd_hit[p] = (32'(rid) < RHT_DEPTH) && (off < 32'(count_q));
      rd_Ldst[p*L_ADDR_WIDTH +: L_ADDR_WIDTH] = e.ldst;
      rd_Pdst[p*P_ADDR_WIDTH +: P_ADDR_WIDTH] = e.pdst;
    end
  end

endmodule

// File: tb/tb_rht_queue.sv
module tb_rht_queue;

  localparam int D = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  push_valid;
  logic [9:0]  push_data_Ldst;
  logic [15:0] push_data_Pdst;
  logic        push_ready;
  logic [13:0] id_out;
  logic [1:0]  pop_count;
  logic [15:0] pop_Pdst;
  logic [1:0]  pop_valid;
  logic        set_ptr;
  logic [6:0]  new_pointer;
  logic [13:0] rd_id;
  logic [9:0]  rd_Ldst;
  logic [15:0] rd_Pdst;
  logic [1:0]  rd_hit;
  logic [7:0]  count;
  logic        empty, full;

  // small non power-of-two instance
  logic        s_rst;
  logic [1:0]  s_push_valid;
  logic [9:0]  s_push_data_Ldst;
  logic [15:0] s_push_data_Pdst;
  logic        s_push_ready;
  logic [5:0]  s_id_out;
  logic [1:0]  s_pop_count;
  logic [15:0] s_pop_Pdst;
  logic [1:0]  s_pop_valid;
  logic        s_set_ptr;
  logic [2:0]  s_new_pointer;
  logic [5:0]  s_rd_id;
  logic [9:0]  s_rd_Ldst;
  logic [15:0] s_rd_Pdst;
  logic [1:0]  s_rd_hit;
  logic [2:0]  s_count;
  logic        s_empty, s_full;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  rht_queue dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_data_Ldst(push_data_Ldst),
    .push_data_Pdst(push_data_Pdst), .push_ready(push_ready), .id_out(id_out),
    .pop_count(pop_count), .pop_Pdst(pop_Pdst), .pop_valid(pop_valid),
    .set_ptr(set_ptr), .new_pointer(new_pointer), .rd_id(rd_id), .rd_Ldst(rd_Ldst),
    .rd_Pdst(rd_Pdst), .rd_hit(rd_hit), .count(count), .empty(empty), .full(full)
  );

  rht_queue #(.RHT_DEPTH(6)) dut6 (
    .clk(clk), .rst(s_rst), .push_valid(s_push_valid), .push_data_Ldst(s_push_data_Ldst),
    .push_data_Pdst(s_push_data_Pdst), .push_ready(s_push_ready), .id_out(s_id_out),
    .pop_count(s_pop_count), .pop_Pdst(s_pop_Pdst), .pop_valid(s_pop_valid),
    .set_ptr(s_set_ptr), .new_pointer(s_new_pointer), .rd_id(s_rd_id), .rd_Ldst(s_rd_Ldst),
    .rd_Pdst(s_rd_Pdst), .rd_hit(s_rd_hit), .count(s_count), .empty(s_empty), .full(s_full)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive the main instance at the falling edge; outputs settle by #1.
  task automatic cyc(input logic [1:0] pv, input int l0, input int l1, input int p0,
                     input int p1, input int pop, input bit sp, input int np,
                     input int r0, input int r1);
    @(negedge clk);
    push_valid     = pv;
    push_data_Ldst = {5'(l1), 5'(l0)};
    push_data_Pdst = {8'(p1), 8'(p0)};
    pop_count      = 2'(pop);
    set_ptr        = sp;
    new_pointer    = 7'(np);
    rd_id          = {7'(r1), 7'(r0)};
    #1;
  endtask

  task automatic scyc(input logic [1:0] pv, input int l0, input int l1, input int p0,
                      input int p1, input int pop, input int r0, input int r1);
    @(negedge clk);
    s_push_valid     = pv;
    s_push_data_Ldst = {5'(l1), 5'(l0)};
    s_push_data_Pdst = {8'(p1), 8'(p0)};
    s_pop_count      = 2'(pop);
    s_rd_id          = {3'(r1), 3'(r0)};
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    push_valid = '0; pop_count = '0; set_ptr = 1'b0; new_pointer = '0; rd_id = '0;
    push_data_Ldst = '0; push_data_Pdst = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] pv; int l0, l1, p0, p1; int pop; bit sp; int np; int rd0, rd1;
    int e_cnt; bit e_rdy; int e_id0, e_id1; logic [1:0] e_pv; int e_pp0, e_pp1;
    logic [1:0] e_hit; int e_l0, e_p0, e_l1, e_p1;
  } vec_t;

  vec_t tbl [12];

  // reference model state
  int mh, mt, mc;
  int mL [D];
  int mP [D];

  initial begin
    rst = 1'b1;
    s_rst = 1'b1;
    s_push_valid = '0; s_push_data_Ldst = '0; s_push_data_Pdst = '0;
    s_pop_count = '0; s_set_ptr = 1'b0; s_new_pointer = '0; s_rd_id = '0;

    //          pv     l0 l1 p0  p1  pop sp np rd0 rd1  cnt rdy id0 id1 popv  pp0 pp1 hit  l0 p0  l1 p1
    tbl[0]  = '{2'b11, 3, 4, 40, 41, 0, 0, 0,  0, 127, 0, 1, 0, 1, 2'b00, 0,  0, 2'b00, 0, 0,  0, 0};
    tbl[1]  = '{2'b00, 0, 0, 0,  0,  0, 0, 0,  1, 0,   2, 1, 2, 2, 2'b00, 0,  0, 2'b11, 4, 41, 3, 40};
    tbl[2]  = '{2'b11, 5, 6, 50, 51, 0, 0, 0,  2, 127, 2, 1, 2, 3, 2'b00, 0,  0, 2'b00, 0, 0,  0, 0};
    tbl[3]  = '{2'b01, 8, 0, 80, 0,  0, 0, 0,  3, 127, 4, 1, 4, 5, 2'b00, 0,  0, 2'b01, 6, 51, 0, 0};
    tbl[4]  = '{2'b10, 9, 10, 90, 100, 0, 0, 0, 4, 5,  5, 1, 5, 5, 2'b00, 0,  0, 2'b01, 8, 80, 0, 0};
    tbl[5]  = '{2'b00, 0, 0, 0,  0,  0, 0, 0,  5, 6,   6, 1, 6, 6, 2'b00, 0,  0, 2'b01, 10, 100, 0, 0};
    tbl[6]  = '{2'b00, 0, 0, 0,  0,  2, 0, 0,  0, 127, 6, 1, 6, 6, 2'b11, 40, 41, 2'b01, 3, 40, 0, 0};
    tbl[7]  = '{2'b00, 0, 0, 0,  0,  1, 0, 0,  1, 5,   4, 1, 6, 6, 2'b01, 50, 0, 2'b10, 0, 0,  10, 100};
    tbl[8]  = '{2'b11, 20, 21, 200, 201, 1, 1, 4, 5, 2, 3, 1, 6, 7, 2'b01, 51, 0, 2'b01, 10, 100, 0, 0};
    tbl[9]  = '{2'b01, 11, 0, 110, 0, 0, 0, 0, 4, 6,   0, 1, 4, 5, 2'b00, 0,  0, 2'b00, 0, 0,  0, 0};
    tbl[10] = '{2'b00, 0, 0, 0,  0,  2, 0, 0,  4, 127, 1, 1, 5, 5, 2'b01, 110, 0, 2'b01, 11, 110, 0, 0};
    tbl[11] = '{2'b00, 0, 0, 0,  0,  0, 0, 0,  4, 127, 0, 1, 5, 5, 2'b00, 0,  0, 2'b00, 0, 0,  0, 0};

    // ---- reset state ----
    do_reset();
    cyc(2'b00, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_ready", int'(push_ready), 1);
    chk("reset_pop_valid", int'(pop_valid), 0);

    // ---- directed table ----
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].pv, tbl[i].l0, tbl[i].l1, tbl[i].p0, tbl[i].p1, tbl[i].pop,
          tbl[i].sp, tbl[i].np, tbl[i].rd0, tbl[i].rd1);
      chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("v%0d_empty", i), int'(empty), int'(tbl[i].e_cnt == 0));
      chk($sformatf("v%0d_ready", i), int'(push_ready), int'(tbl[i].e_rdy));
      chk($sformatf("v%0d_id0", i), int'(id_out[6:0]), tbl[i].e_id0);
      chk($sformatf("v%0d_id1", i), int'(id_out[13:7]), tbl[i].e_id1);
      chk($sformatf("v%0d_pop_valid", i), int'(pop_valid), int'(tbl[i].e_pv));
      if (tbl[i].e_pv[0]) chk($sformatf("v%0d_pop_pdst0", i), int'(pop_Pdst[7:0]), tbl[i].e_pp0);
      if (tbl[i].e_pv[1]) chk($sformatf("v%0d_pop_pdst1", i), int'(pop_Pdst[15:8]), tbl[i].e_pp1);
      chk($sformatf("v%0d_rd_hit", i), int'(rd_hit), int'(tbl[i].e_hit));
      if (tbl[i].e_hit[0]) begin
        chk($sformatf("v%0d_rd0_ldst", i), int'(rd_Ldst[4:0]), tbl[i].e_l0);
        chk($sformatf("v%0d_rd0_pdst", i), int'(rd_Pdst[7:0]), tbl[i].e_p0);
      end
      if (tbl[i].e_hit[1]) begin
        chk($sformatf("v%0d_rd1_ldst", i), int'(rd_Ldst[9:5]), tbl[i].e_l1);
        chk($sformatf("v%0d_rd1_pdst", i), int'(rd_Pdst[15:8]), tbl[i].e_p1);
      end
    end

    // ---- fill to 127: backpressure, drop, pop releases ----
    do_reset();
    for (int j = 0; j < 63; j++)
      cyc(2'b11, (2*j) % 32, (2*j+1) % 32, (2*j+1) % 256, (2*j+2) % 256, 0, 0, 0, 0, 0);
    cyc(2'b01, 30, 0, 127, 0, 0, 0, 0, 0, 0);
    chk("fill_ready_126", int'(push_ready), 1);
    cyc(2'b11, 1, 1, 9, 9, 0, 0, 0, 126, 127);
    chk("fill_count_127", int'(count), 127);
    chk("fill_ready_low", int'(push_ready), 0);
    chk("fill_full_low", int'(full), 0);
    chk("fill_rd_hit", int'(rd_hit), 1);
    chk("fill_rd126_pdst", int'(rd_Pdst[7:0]), 127);
    cyc(2'b11, 1, 1, 9, 9, 2, 0, 0, 127, 0);
    chk("drop_count", int'(count), 127);
    chk("drop_rd_hit", int'(rd_hit), 2);
    chk("full_pop_valid", int'(pop_valid), 3);
    chk("full_pop_pdst0", int'(pop_Pdst[7:0]), 1);
    chk("full_pop_pdst1", int'(pop_Pdst[15:8]), 2);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("after_pop_count", int'(count), 125);
    chk("after_pop_ready", int'(push_ready), 1);

    // ---- reset during push ----
    @(negedge clk);
    rst = 1'b1;
    push_valid = 2'b11;
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);

    // ---- randomized run against the reference model ----
    do_reset();
    mh = 0; mt = 0; mc = 0;
    for (int c = 0; c < 2500; c++) begin
      logic [1:0] pv;
      int l0, l1, p0, p1, pop, eff, np, r0, r1, fl, n, pos;
      bit sp, rdy, fire;
      pv  = 2'($urandom_range(0, 3));
      l0 = $urandom_range(0, 31); l1 = $urandom_range(0, 31);
      p0 = $urandom_range(0, 255); p1 = $urandom_range(0, 255);
      if (c < 700) pop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0;
      else         pop = $urandom_range(0, 2);
      eff = (pop < mc) ? pop : mc;
      sp  = (c >= 700) && ($urandom_range(0, 15) == 0);
      np  = (mh + eff + $urandom_range(0, mc - eff)) % D;
      r0  = (mh + $urandom_range(0, 127)) % D;
      r1  = $urandom_range(0, 127);
      cyc(pv, l0, l1, p0, p1, pop, sp, np, r0, r1);

      rdy = (D - mc) >= 2;
      chk("rnd_count", int'(count), mc);
      chk("rnd_empty", int'(empty), int'(mc == 0));
      chk("rnd_full", int'(full), int'(mc == D));
      chk("rnd_ready", int'(push_ready), int'(rdy));
      chk("rnd_id0", int'(id_out[6:0]), mt);
      chk("rnd_id1", int'(id_out[13:7]), (mt + int'(pv[0])) % D);
      chk("rnd_pop_valid", int'(pop_valid), (eff == 2) ? 3 : (eff == 1) ? 1 : 0);
      if (eff >= 1) chk("rnd_pop_pdst0", int'(pop_Pdst[7:0]), mP[mh]);
      if (eff >= 2) chk("rnd_pop_pdst1", int'(pop_Pdst[15:8]), mP[(mh + 1) % D]);
      chk("rnd_hit0", int'(rd_hit[0]), int'(((r0 - mh + D) % D) < mc));
      chk("rnd_hit1", int'(rd_hit[1]), int'(((r1 - mh + D) % D) < mc));
      if (((r0 - mh + D) % D) < mc) begin
        chk("rnd_rd0_ldst", int'(rd_Ldst[4:0]), mL[r0]);
        chk("rnd_rd0_pdst", int'(rd_Pdst[7:0]), mP[r0]);
      end
      if (((r1 - mh + D) % D) < mc) begin
        chk("rnd_rd1_ldst", int'(rd_Ldst[9:5]), mL[r1]);
        chk("rnd_rd1_pdst", int'(rd_Pdst[15:8]), mP[r1]);
      end

      // next state from the queue rules
      fl = 0; n = 0;
      fire = rdy && (pv != 0) && !sp;
      if (sp) begin
        fl = (mt - np + D) % D;
        mt = np;
      end else if (fire) begin
        pos = mt;
        if (pv[0]) begin mL[pos] = l0; mP[pos] = p0; pos = (pos + 1) % D; n++; end
        if (pv[1]) begin mL[pos] = l1; mP[pos] = p1; pos = (pos + 1) % D; n++; end
        mt = pos;
      end
      mc = mc + n - eff - fl;
      mh = (mh + eff) % D;
    end

    // ---- depth 6 wrap ----
    @(negedge clk);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    scyc(2'b11, 1, 2, 11, 12, 0, 0, 0);
    chk("d6_id0_start", int'(s_id_out[2:0]), 0);
    scyc(2'b11, 3, 4, 13, 14, 0, 0, 0);
    scyc(2'b01, 5, 0, 15, 0, 2, 0, 0);
    chk("d6_pop_valid", int'(s_pop_valid), 3);
    chk("d6_pop_pdst1", int'(s_pop_Pdst[15:8]), 12);
    chk("d6_id0_4", int'(s_id_out[2:0]), 4);
    scyc(2'b11, 6, 7, 16, 17, 0, 0, 0);
    chk("d6_count_3", int'(s_count), 3);
    chk("d6_wrap_id0", int'(s_id_out[2:0]), 5);
    chk("d6_wrap_id1", int'(s_id_out[5:3]), 0);
    scyc(2'b00, 0, 0, 0, 0, 0, 0, 5);
    chk("d6_count_5", int'(s_count), 5);
    chk("d6_tail_1", int'(s_id_out[2:0]), 1);
    chk("d6_ready_low", int'(s_push_ready), 0);
    chk("d6_rd_hit", int'(s_rd_hit), 3);
    chk("d6_rd0_ldst", int'(s_rd_Ldst[4:0]), 7);
    chk("d6_rd0_pdst", int'(s_rd_Pdst[7:0]), 17);
    chk("d6_rd1_pdst", int'(s_rd_Pdst[15:8]), 16);
    scyc(2'b00, 0, 0, 0, 0, 0, 7, 1);
    chk("d6_bad_id_nohit", int'(s_rd_hit), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
